// File: rtl/motor_ramp_sched.sv
// rtl/motor_ramp_sched.sv - slew-rate limited, reversal-braking duty scheduler for lft/rht motor commands
//
// Sits ahead of the PWM controller. Each channel walks toward its latched
// target by STEP per ramp tick (one tick every PRESCALE clocks). A direction
// reversal goes through zero and holds there for DWELL clocks. estop forces
// both channels and targets to zero.
//
// Optional build macro: DECEL_FAST_EN - moves toward zero use 2*STEP per tick.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   lft_tgt, rht_tgt    signed 11-bit targets, latched on tgt_vld
//   tgt_vld             one-cycle target strobe
//   estop               level emergency stop
//   lft, rht            signed 11-bit registered motor commands
//   busy                state is not IDLE
//   dwell_act           state is DWELL
//   at_tgt              state is IDLE (both channels at target)

module motor_ramp_sched #(
    parameter int STEP     = 16,
    parameter int PRESCALE = 1024,
    parameter int DWELL    = 4096
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic signed [10:0] lft_tgt,
    input  logic signed [10:0] rht_tgt,
    input  logic               tgt_vld,
    input  logic               estop,
    output logic signed [10:0] lft,
    output logic signed [10:0] rht,
    output logic               busy,
    output logic               dwell_act,
    output logic               at_tgt
);

    localparam int PW  = $clog2(PRESCALE);
    localparam int DWW = $clog2(DWELL + 1);

    localparam logic signed [11:0] ACC12 = 12'(STEP);
`ifdef DECEL_FAST_EN
    localparam logic signed [11:0] DEC12 = 12'(2 * STEP);
`else
    localparam logic signed [11:0] DEC12 = 12'(STEP);
`endif

    localparam logic [PW-1:0]  PRE_LAST = PW'(PRESCALE - 1);
    localparam logic [DWW-1:0] DWL_LAST = DWW'(DWELL - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_RAMP,
        S_DWELL,
        S_ESTOP
    } state_t;

    state_t             state_q, state_d;
    logic signed [10:0] lft_q, lft_d;
    logic signed [10:0] rht_q, rht_d;
    logic signed [10:0] lt_q, lt_d;
    logic signed [10:0] rt_q, rt_d;
    logic [PW-1:0]      pre_q, pre_d;
    logic [DWW-1:0]     dwl_q, dwl_d;

    logic               tick;
    logic signed [10:0] lft_nx, rht_nx;
    logic               lft_brk, rht_brk;

    // Opposite signs: the channel has to pass through zero before heading to tgt.
    function automatic logic crossing(input logic signed [10:0] cur,
                                      input logic signed [10:0] tgt);
        return ((cur > 11'sd0) && (tgt < 11'sd0)) ||
               ((cur < 11'sd0) && (tgt > 11'sd0));
    endfunction

    // One ramp step, computed in 12 bits so cur +/- step cannot wrap before clamping.
    function automatic logic signed [10:0] step_ch(input logic signed [10:0] cur,
                                                   input logic signed [10:0] tgt);
        logic signed [11:0] c;
        logic signed [11:0] t;
        logic signed [11:0] n;
        c = {cur[10], cur};
        t = {tgt[10], tgt};
        n = c;
        if (cur == tgt) begin
            n = c;
        end else if (crossing(cur, tgt) || (tgt == 11'sd0)) begin
            if (c > 12'sd0) begin
                n = c - DEC12;
                if (n < 12'sd0) n = 12'sd0;
            end else begin
                n = c + DEC12;
                if (n > 12'sd0) n = 12'sd0;
            end
        end else if (t > c) begin
            n = c + ACC12;
            if (n > t) n = t;
        end else begin
            n = c - ACC12;
            if (n < t) n = t;
        end
        return n[10:0];
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            lft_q   <= '0;
            rht_q   <= '0;
            lt_q    <= '0;
            rt_q    <= '0;
            pre_q   <= '0;
            dwl_q   <= '0;
        end else begin
            state_q <= state_d;
            lft_q   <= lft_d;
            rht_q   <= rht_d;
            lt_q    <= lt_d;
            rt_q    <= rt_d;
            pre_q   <= pre_d;
            dwl_q   <= dwl_d;
        end
    end

    always_comb begin
        state_d = state_q;
        lft_d   = lft_q;
        rht_d   = rht_q;
        lt_d    = lt_q;
        rt_d    = rt_q;
        pre_d   = pre_q;
        dwl_d   = dwl_q;

        tick    = (pre_q == PRE_LAST);
        // Steps always use the targets held before this edge, so a strobe
        // coinciding with a tick only takes effect from the following tick.
        lft_nx  = step_ch(lft_q, lt_q);
        rht_nx  = step_ch(rht_q, rt_q);
        // Reaching zero mid-reversal requires the brake dwell.
        lft_brk = (lft_q != 11'sd0) && (lft_nx == 11'sd0) && crossing(lft_q, lt_q);
        rht_brk = (rht_q != 11'sd0) && (rht_nx == 11'sd0) && crossing(rht_q, rt_q);

        if (estop) begin
            state_d = S_ESTOP;
            lft_d   = '0;
            rht_d   = '0;
            lt_d    = '0;
            rt_d    = '0;
            pre_d   = '0;
            dwl_d   = '0;
        end else begin
            if (tgt_vld && (state_q != S_ESTOP)) begin
                lt_d = lft_tgt;
                rt_d = rht_tgt;
            end

            case (state_q)
                S_IDLE: begin
                    pre_d = '0;
                    if ((lt_q != lft_q) || (rt_q != rht_q)) state_d = S_RAMP;
                end
                S_RAMP: begin
                    if (tick) begin
                        pre_d = '0;
                        lft_d = lft_nx;
                        rht_d = rht_nx;
                        if (lft_brk || rht_brk) begin
                            state_d = S_DWELL;
                            dwl_d   = '0;
                        end else if ((lft_nx == lt_q) && (rht_nx == rt_q)) begin
                            state_d = S_IDLE;
                        end
                    end else begin
                        pre_d = pre_q + 1'b1;
                    end
                end
                S_DWELL: begin
                    pre_d = '0;
                    if (dwl_q == DWL_LAST) begin
                        dwl_d = '0;
                        if ((lft_q == lt_q) && (rht_q == rt_q)) state_d = S_IDLE;
                        else                                    state_d = S_RAMP;
                    end else begin
                        dwl_d = dwl_q + 1'b1;
                    end
                end
                S_ESTOP: begin
                    state_d = S_IDLE;
                end
                default: begin
                    state_d = S_IDLE;
                end
            endcase
        end
    end

    assign lft       = lft_q;
    assign rht       = rht_q;
    assign busy      = (state_q != S_IDLE);
    assign dwell_act = (state_q == S_DWELL);
    assign at_tgt    = (state_q == S_IDLE);

endmodule

// File: tb/tb_motor_ramp_sched.sv
// tb/tb_motor_ramp_sched.sv - directed self-checking bench for motor_ramp_sched

module tb_motor_ramp_sched;

    localparam int STEP     = 16;
    localparam int PRESCALE = 4;
    localparam int DWELL    = 8;
`ifdef DECEL_FAST_EN
    localparam int MAX_JUMP = 32;
`else
    localparam int MAX_JUMP = 16;
`endif

    logic               clk;
    logic               rst_n;
    logic signed [10:0] lft_tgt;
    logic signed [10:0] rht_tgt;
    logic               tgt_vld;
    logic               estop;
    logic signed [10:0] lft;
    logic signed [10:0] rht;
    logic               busy;
    logic               dwell_act;
    logic               at_tgt;

    int n_tests = 0;
    int n_fail  = 0;
    logic saw_dwell;

    motor_ramp_sched #(
        .STEP     (STEP),
        .PRESCALE (PRESCALE),
        .DWELL    (DWELL)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .lft_tgt   (lft_tgt),
        .rht_tgt   (rht_tgt),
        .tgt_vld   (tgt_vld),
        .estop     (estop),
        .lft       (lft),
        .rht       (rht),
        .busy      (busy),
        .dwell_act (dwell_act),
        .at_tgt    (at_tgt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Strobe a target on the next rising edge; returns at the following negedge.
    task automatic set_tgt(input int l, input int r);
        lft_tgt = 11'(l);
        rht_tgt = 11'(r);
        tgt_vld = 1'b1;
        @(negedge clk);
        tgt_vld = 1'b0;
    endtask

    // Wait for lft to change; check new value and the number of clocks it took.
    task automatic wait_lft(input string tag, input int exp_val, input int exp_cyc);
        int prev;
        int n;
        prev = int'(lft);
        n    = 0;
        do begin
            @(negedge clk);
            n++;
        end while ((int'(lft) == prev) && (n < 64));
        check({tag, "_val"}, int'(lft), exp_val);
        check({tag, "_cyc"}, n, exp_cyc);
    endtask

    // Run until back in IDLE, tracking per-cycle jumps and whether DWELL was seen.
    task automatic run_to_idle(input string tag, input int limit);
        int prev;
        int d;
        int n;
        int big;
        prev      = int'(lft);
        n         = 0;
        big       = 0;
        saw_dwell = 1'b0;
        do begin
            @(negedge clk);
            n++;
            d = int'(lft) - prev;
            if ((d > MAX_JUMP) || (d < -MAX_JUMP)) big++;
            prev = int'(lft);
            if (dwell_act) saw_dwell = 1'b1;
        end while (((n < 2) || !at_tgt) && (n < limit));
        check({tag, "_idle"}, int'(at_tgt), 1);
        check({tag, "_slew"}, big, 0);
    endtask

    initial begin
        int cnt;
        rst_n   = 1'b0;
        lft_tgt = '0;
        rht_tgt = '0;
        tgt_vld = 1'b0;
        estop   = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_lft", int'(lft), 0);
        check("rst_rht", int'(rht), 0);
        check("rst_busy", int'(busy), 0);
        check("rst_dwell", int'(dwell_act), 0);
        check("rst_at_tgt", int'(at_tgt), 1);
        rst_n = 1'b1;
        @(negedge clk);

        // 1: accelerate 0 -> 100
        set_tgt(100, 0);
        wait_lft("t1_s1", 16, 5);
        wait_lft("t1_s2", 32, 4);
        wait_lft("t1_s3", 48, 4);
        wait_lft("t1_s4", 64, 4);
        wait_lft("t1_s5", 80, 4);
        wait_lft("t1_s6", 96, 4);
        wait_lft("t1_s7", 100, 4);
        check("t1_at_tgt", int'(at_tgt), 1);
        check("t1_busy", int'(busy), 0);
        check("t1_rht", int'(rht), 0);

`ifdef DECEL_FAST_EN
        // 6: fast decel 100 -> 0, no dwell since tgt is zero
        set_tgt(0, 0);
        wait_lft("t6_s1", 68, 5);
        wait_lft("t6_s2", 36, 4);
        wait_lft("t6_s3", 4, 4);
        wait_lft("t6_s4", 0, 4);
        check("t6_no_dwell", int'(dwell_act), 0);
        check("t6_at_tgt", int'(at_tgt), 1);
        repeat (3) @(negedge clk);
        check("t6_hold", int'(lft), 0);
`else
        // 2: reversal 100 -> -50 through a brake dwell
        set_tgt(-50, 0);
        wait_lft("t2_d1", 84, 5);
        wait_lft("t2_d2", 68, 4);
        wait_lft("t2_d3", 52, 4);
        wait_lft("t2_d4", 36, 4);
        wait_lft("t2_d5", 20, 4);
        wait_lft("t2_d6", 4, 4);
        wait_lft("t2_d7", 0, 4);
        cnt = 0;
        while (dwell_act && (cnt < 100)) begin
            cnt++;
            @(negedge clk);
        end
        check("t2_dwell_len", cnt, 8);
        check("t2_dwell_lft", int'(lft), 0);
        wait_lft("t2_a1", -16, 4);
        wait_lft("t2_a2", -32, 4);
        wait_lft("t2_a3", -48, 4);
        wait_lft("t2_a4", -50, 4);
        check("t2_at_tgt", int'(at_tgt), 1);
`endif

        // 3: full-scale saturation both directions
        set_tgt(1023, 0);
        run_to_idle("t3_pos", 2000);
        check("t3_pos_val", int'(lft), 1023);
        set_tgt(-1024, 0);
        run_to_idle("t3_neg", 2000);
        check("t3_neg_val", int'(lft), -1024);
        check("t3_neg_dwell", int'(saw_dwell), 1);

        // 4: estop mid-ramp
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        set_tgt(100, 0);
        wait_lft("t4_s1", 16, 5);
        wait_lft("t4_s2", 32, 4);
        wait_lft("t4_s3", 48, 4);
        estop = 1'b1;
        @(negedge clk);
        check("t4_es_lft", int'(lft), 0);
        check("t4_es_rht", int'(rht), 0);
        check("t4_es_busy", int'(busy), 1);
        check("t4_es_at_tgt", int'(at_tgt), 0);
        set_tgt(200, 0);
        repeat (3) @(negedge clk);
        check("t4_es_hold", int'(lft), 0);
        estop = 1'b0;
        @(negedge clk);
        check("t4_rel_at_tgt", int'(at_tgt), 1);
        repeat (8) @(negedge clk);
        check("t4_rel_lft", int'(lft), 0);
        check("t4_rel_busy", int'(busy), 0);

        // 5: asynchronous reset in the middle of a dwell
        set_tgt(20, 60);
        run_to_idle("t5_up", 500);
        check("t5_up_lft", int'(lft), 20);
        check("t5_up_rht", int'(rht), 60);
        set_tgt(-20, 60);
        cnt = 0;
        while (!dwell_act && (cnt < 50)) begin
            cnt++;
            @(negedge clk);
        end
        check("t5_dwell", int'(dwell_act), 1);
        check("t5_dw_rht", int'(rht), 60);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("t5_async_rht", int'(rht), 0);
        check("t5_async_lft", int'(lft), 0);
        check("t5_async_dwell", int'(dwell_act), 0);
        check("t5_async_at_tgt", int'(at_tgt), 1);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("t5_post_at_tgt", int'(at_tgt), 1);
        check("t5_post_rht", int'(rht), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule

// File: doc/motor_ramp_sched.md
Name: motor_ramp_sched

Overview:
- Sits upstream of the motor PWM controller and drives its signed 11-bit lft/rht duty commands.
- Accepts target commands from the command/navigation logic and slew-rate limits each channel toward its target.
- Forces a brake dwell at zero before any direction reversal.
- Provides an emergency-stop override that brakes both motors immediately.

Parameters:
STEP, 16, magnitude change per ramp tick (1..511)
PRESCALE, 1024, clock cycles per ramp tick (>=2)
DWELL, 4096, clock cycles held at zero (brake) before reversing direction (>=1)

Ports:
clk  input  1  system clock
rst_n  input  1  asynchronous active-low reset
lft_tgt  input  11  signed target, left motor
rht_tgt  input  11  signed target, right motor
tgt_vld  input  1  one-cycle strobe, latch lft_tgt/rht_tgt
estop  input  1  level, emergency stop
lft  output  11  signed registered command to motor controller, left
rht  output  11  signed registered command to motor controller, right
busy  output  1  high when state != IDLE
dwell_act  output  1  high in DWELL
at_tgt  output  1  high in IDLE (both channels equal their targets)

Behaviour:
- Reset: one clock; reset is asynchronous and active-low.
  - Asserting rst_n low immediately clears lft, rht, both target regs, prescaler and dwell counter.
  - State goes to IDLE; busy=0, dwell_act=0, at_tgt=1.
- Arithmetic: two's complement, range -1024..1023. Next values are computed in 12 bits and clamped, so no wrap.
- Target latch: on tgt_vld with estop=0, tgt regs load on the same edge in any state except ESTOP. tgt_vld is ignored during estop.
- Per-channel step, applied on a tick (prescaler == PRESCALE-1):
  - cur == tgt: hold.
  - Crossing needed (cur>0 and tgt<0, or cur<0 and tgt>0) or tgt == 0: move toward 0 by STEP, clamp at 0.
  - Otherwise: move toward tgt by STEP, clamp at tgt.
  - Both channels step on the same tick.
- FSM states: IDLE, RAMP, DWELL, ESTOP.
  - IDLE: prescaler held at 0. A latched target differing from cur on either channel -> RAMP on the next edge.
  - RAMP: prescaler counts 0..PRESCALE-1 and wraps. First tick occurs PRESCALE cycles after entry; lft/rht update on the tick edge.
    - If a tick takes a channel from nonzero to 0 and that channel still needs a crossing -> DWELL, dwell counter = 0.
    - Else if both channels equal their targets after the tick -> IDLE.
  - DWELL: lft/rht frozen for exactly DWELL cycles, then -> RAMP with prescaler = 0.
    - The other channel is also frozen.
    - New targets latch but do not shorten the dwell.
    - If after dwell both cur == tgt -> IDLE directly.
  - ESTOP: estop=1 in any state -> on the next edge lft=rht=0, tgt regs = 0, prescaler and dwell cleared, state ESTOP.
    - Held while estop=1; estop=0 -> IDLE.
    - Zero output means the motor controller brakes (all outputs high).
- Simultaneous events:
  - estop beats tgt_vld and tick.
  - A tgt_vld on a tick edge: the tick uses the old target; the new target applies from the next tick.
  - Retarget mid-RAMP to a value already equal to cur -> IDLE on the next tick.

Optional Feature:
DECEL_FAST_EN
- Defined: moves toward 0 (crossing or tgt==0) use 2*STEP per tick, clamp at 0. Acceleration away from 0 is unchanged.
- Undefined: all moves use STEP.

Test Plan:
Bench uses STEP=16, PRESCALE=4, DWELL=8, macro undefined unless stated.
1. Reset, then tgt_vld lft_tgt=100 rht_tgt=0 -> lft steps 16,32,48,64,80,96,100 every 4 cycles; at_tgt=1 after the 7th tick; rht stays 0.
2. From lft=100, tgt_vld lft_tgt=-50 -> lft 84,68,52,36,20,4,0; dwell_act=1 for exactly 8 cycles; then -16,-32,-48,-50; at_tgt=1.
3. lft_tgt=1023 then -1024 -> lft saturates at 1023, reverses via 0 with dwell, ends at -1024; no overflow on any cycle.
4. estop asserted mid-RAMP at lft=48 -> next edge lft=rht=0, busy=1, at_tgt=0; tgt_vld 200 during estop ignored; release -> IDLE, lft stays 0.
5. rst_n pulsed low mid-DWELL -> outputs 0 asynchronously, before the next clk edge; after release IDLE, at_tgt=1.
6. DECEL_FAST_EN defined, lft 100 -> 0 -> lft 68,36,4,0 (4 ticks); no DWELL because tgt==0.
